// File: rtl/bsg_fifo_pkg.sv
// Shared types for the small FIFO: pointer and occupancy widths plus pointer increment.
// The els_lp depth here must match the FIFO's els_p.
package bsg_fifo_pkg;

   localparam int els_lp    = 4;
   localparam int lg_els_lp = $clog2(els_lp);

   typedef logic [lg_els_lp-1:0] ptr_t;
   typedef logic [lg_els_lp:0]   count_t;

   // Power-of-two depth, so the natural overflow is the wrap to entry 0.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write one-read register array: synchronous write, asynchronous read.
// Contents are never reset; the FIFO flags decide what is meaningful.
module bsg_mem_1r1w #(
   parameter  int width_p   = 32,
   parameter  int els_p     = 4,
   localparam int addr_w_lp = $clog2(els_p)
) (
   input  logic                 clk_i,
   input  logic                 w_v_i,
   input  logic [addr_w_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]   w_data_i,
   input  logic [addr_w_lp-1:0] r_addr_i,
   output logic [width_p-1:0]   r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_fifo_small_width_p32.sv
// Small synchronous FIFO (valid/ready in, valid/yumi out) with registered pointers and flags.
// Define BSG_FIFO_COUNT_EN to add the count_o occupancy output.
module bsg_fifo_small_width_p32
   import bsg_fifo_pkg::*;
#(
   parameter int width_p = 32,
   parameter int els_p   = els_lp
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
`ifdef BSG_FIFO_COUNT_EN
   ,
   output count_t             count_o
`endif
);

   ptr_t rptr_q, rptr_d;
   ptr_t wptr_q, wptr_d;
   logic full_q, full_d;
   logic empty_q, empty_d;
   logic enq, deq;

   assign ready_o = ~full_q & ~reset_i;
   assign v_o     = ~empty_q;
   assign enq     = v_i & ready_o;
   // An illegal yumi on an empty FIFO must not disturb the pointers.
   assign deq     = yumi_i & ~empty_q;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      full_d  = full_q;
      empty_d = empty_q;
      if (enq) wptr_d = ptr_inc(wptr_q);
      if (deq) rptr_d = ptr_inc(rptr_q);
      if (enq & ~deq) begin
         empty_d = 1'b0;
         full_d  = (ptr_inc(wptr_q) == rptr_q);
      end else if (deq & ~enq) begin
         full_d  = 1'b0;
         empty_d = (ptr_inc(rptr_q) == wptr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   bsg_mem_1r1w #(
      .width_p (width_p),
      .els_p   (els_p)
   ) mem (
      .clk_i    (clk_i),
      .w_v_i    (enq),
      .w_addr_i (wptr_q),
      .w_data_i (data_i),
      .r_addr_i (rptr_q),
      .r_data_o (data_o)
   );

`ifdef BSG_FIFO_COUNT_EN
   count_t count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (enq & ~deq)      count_d = count_q + count_t'(1);
      else if (deq & ~enq) count_d = count_q - count_t'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert ((count_q == count_t'(els_p)) == full_q)
            else $error("bsg_fifo_small_width_p32: count_o disagrees with full flag");
      end
   end
`endif

   // Consumer protocol check: yumi is only legal while an entry is presented.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(yumi_i && empty_q))
            else $error("bsg_fifo_small_width_p32: yumi_i asserted while empty");
      end
   end

endmodule

// File: tb/tb_bsg_fifo_small_width_p32.sv
// Directed bench for bsg_fifo_small_width_p32: vector table plus hand-written corner sequences.
// count_o is checked only when BSG_FIFO_COUNT_EN is defined.
module tb_bsg_fifo_small_width_p32;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        v_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        ready_o;
   logic        v_o;
   logic [31:0] data_o;
   logic        yumi_i = 1'b0;
`ifdef BSG_FIFO_COUNT_EN
   logic [2:0]  count_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   bsg_fifo_small_width_p32 dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i)
`ifdef BSG_FIFO_COUNT_EN
      ,
      .count_o (count_o)
`endif
   );

   typedef struct {
      logic        rst;
      logic        v;
      logic [31:0] d;
      logic        y;
      logic        rdy;
      logic        vo;
      logic [31:0] exp_d;
      int          cnt;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input int exp);
`ifdef BSG_FIFO_COUNT_EN
      chk(name, 32'(count_o), 32'(exp));
`else
      if (exp < 0) $display("negative count %0d in %s", exp, name);
`endif
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise.
   task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic y);
      @(negedge clk_i);
      reset_i = r;
      v_i     = v;
      data_i  = d;
      yumi_i  = y;
      #1;
   endtask

   int in_idx;
   int out_idx;

   initial begin
      //            rst v  d             y  rdy vo exp_d         cnt
      vecs[0]  = '{1, 0, 32'h0,        0, 0,  0, 32'h0,        0};
      vecs[1]  = '{1, 0, 32'h0,        0, 0,  0, 32'h0,        0};
      vecs[2]  = '{0, 0, 32'h0,        0, 1,  0, 32'h0,        0};
      vecs[3]  = '{0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,        0};
      vecs[4]  = '{0, 0, 32'h0,        1, 1,  1, 32'hDEADBEEF, 1};
      vecs[5]  = '{0, 0, 32'h0,        0, 1,  0, 32'h0,        0};
      vecs[6]  = '{0, 1, 32'h1,        0, 1,  0, 32'h0,        0};
      vecs[7]  = '{0, 1, 32'h2,        0, 1,  1, 32'h1,        1};
      vecs[8]  = '{0, 1, 32'h3,        0, 1,  1, 32'h1,        2};
      vecs[9]  = '{0, 1, 32'h4,        0, 1,  1, 32'h1,        3};
      vecs[10] = '{0, 1, 32'h5,        0, 0,  1, 32'h1,        4};
      vecs[11] = '{0, 1, 32'h5,        1, 0,  1, 32'h1,        4};
      vecs[12] = '{0, 1, 32'h5,        0, 1,  1, 32'h2,        3};
      vecs[13] = '{0, 0, 32'h0,        1, 0,  1, 32'h2,        4};
      vecs[14] = '{0, 0, 32'h0,        1, 1,  1, 32'h3,        3};
      vecs[15] = '{0, 0, 32'h0,        1, 1,  1, 32'h4,        2};
      vecs[16] = '{0, 0, 32'h0,        1, 1,  1, 32'h5,        1};
      vecs[17] = '{0, 0, 32'h0,        0, 1,  0, 32'h0,        0};

      @(posedge clk_i);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].y);
         chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].rdy));
         chk($sformatf("vec%0d_v", i), 32'(v_o), 32'(vecs[i].vo));
         if (vecs[i].vo) chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
         chk_cnt($sformatf("vec%0d_count", i), vecs[i].cnt);
      end

      // Random-gap stream through several pointer wraps; producer holds data until accepted.
      in_idx  = 0;
      out_idx = 0;
      for (int cyc = 0; cyc < 400 && out_idx < 20; cyc++) begin
         @(negedge clk_i);
         reset_i = 1'b0;
         v_i     = (in_idx < 20) && ($urandom_range(0, 2) != 0);
         data_i  = 32'(in_idx);
         yumi_i  = v_o && ($urandom_range(0, 2) != 0);
         #1;
         if (yumi_i) begin
            chk("stream_data", data_o, 32'(out_idx));
            out_idx++;
         end
         if (v_i && ready_o) in_idx++;
      end
      chk("stream_out_count", 32'(out_idx), 32'd20);
      chk("stream_in_count", 32'(in_idx), 32'd20);
      drive(0, 0, 32'h0, 0);
      chk("stream_drained_v", 32'(v_o), 32'd0);
      chk_cnt("stream_drained_count", 0);

      // Steady occupancy of two with simultaneous enqueue and dequeue.
      drive(0, 1, 32'd100, 0);
      drive(0, 1, 32'd101, 0);
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 32'(102 + k), 1);
         chk("simul_v", 32'(v_o), 32'd1);
         chk("simul_ready", 32'(ready_o), 32'd1);
         chk("simul_data", data_o, 32'(100 + k));
         chk_cnt("simul_count", 2);
      end
      drive(0, 0, 32'h0, 1);
      chk("simul_drain0", data_o, 32'd108);
      drive(0, 0, 32'h0, 1);
      chk("simul_drain1", data_o, 32'd109);
      drive(0, 0, 32'h0, 0);
      chk("simul_empty_v", 32'(v_o), 32'd0);

      // Reset while holding three entries, with yumi asserted during the reset cycle.
      drive(0, 1, 32'd200, 0);
      drive(0, 1, 32'd201, 0);
      drive(0, 1, 32'd202, 0);
      drive(1, 0, 32'h0, 1);
      chk("midrst_ready_in_reset", 32'(ready_o), 32'd0);
      chk("midrst_v_before", 32'(v_o), 32'd1);
      chk_cnt("midrst_count_before", 3);
      drive(0, 0, 32'h0, 0);
      chk("midrst_v_after", 32'(v_o), 32'd0);
      chk("midrst_ready_after", 32'(ready_o), 32'd1);
      chk_cnt("midrst_count_after", 0);
      drive(0, 1, 32'd300, 0);
      drive(0, 0, 32'h0, 0);
      chk("postrst_v", 32'(v_o), 32'd1);
      chk("postrst_data", data_o, 32'd300);
      chk_cnt("postrst_count", 1);
      drive(0, 0, 32'h0, 1);
      chk("postrst_deq_data", data_o, 32'd300);
      drive(0, 0, 32'h0, 0);
      chk("postrst_empty_v", 32'(v_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
